// File: rtl/sbox_pkg.sv
// GF(2^4) arithmetic shared by the composite-field byte inverter.
// Polynomial basis modulo y^4+y+1; GF(2^8) is GF(2^4)[x]/(x^2+x+LAMBDA).
package sbox_pkg;

    typedef logic [3:0] gf4_t;

    localparam logic [4:0] GF4_POLY = 5'b1_0011;
    localparam gf4_t       LAMBDA   = 4'hC;

    // Shift-and-add multiply, reducing by y^4 = y + 1 on each shift.
    function automatic gf4_t gf4_mul(input gf4_t a, input gf4_t b);
        gf4_t acc;
        gf4_t sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[2:0], 1'b0} ^ (sh[3] ? GF4_POLY[3:0] : 4'h0);
        end
        return acc;
    endfunction

    // Squaring is linear in characteristic 2, so it collapses to a few XORs.
    function automatic gf4_t gf4_sq(input gf4_t a);
        return {a[3], a[1] ^ a[3], a[2], a[0] ^ a[2]};
    endfunction

endpackage

// File: rtl/gf4_inv.sv
// GF(2^4) multiplicative inverse (0 maps to 0), computed as a^14.
// Latency: combinational.
// Backpressure: none, pure function of the input.
module gf4_inv
    import sbox_pkg::*;
(
    input  logic [3:0] a,
    output logic [3:0] y
);

    gf4_t a2;
    gf4_t a4;
    gf4_t a8;

    assign a2 = gf4_sq(a);
    assign a4 = gf4_sq(a2);
    assign a8 = gf4_sq(a4);
    assign y  = gf4_mul(gf4_mul(a8, a4), a2);

endmodule

// File: rtl/gf8_inv_pipe.sv
// Composite-field GF(2^8) inverse with encrypt/tag sideband, 3 register stages.
// Latency: 3 cycles accept-to-out_valid; one byte per cycle when out_ready is high.
// Backpressure: each stage loads when empty or draining; in_ready ignores in_valid.
module gf8_inv_pipe
    import sbox_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_encrypt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_encrypt,
    output logic [TAG_W-1:0] out_tag,
    output logic [1:0]       occupancy
);

    logic             s1_vld;
    logic             s2_vld;
    logic             s3_vld;
    logic             ld1;
    logic             ld2;
    logic             ld3;

    gf4_t             in_ah;
    gf4_t             in_al;
    gf4_t             d_c;
    gf4_t             dinv_c;
    gf4_t             out_h_c;
    gf4_t             out_l_c;

    gf4_t             s1_d;
    gf4_t             s1_ah;
    gf4_t             s1_al;
    logic             s1_enc;
    logic [TAG_W-1:0] s1_tag;

    gf4_t             s2_dinv;
    gf4_t             s2_ah;
    gf4_t             s2_al;
    logic             s2_enc;
    logic [TAG_W-1:0] s2_tag;

    logic [7:0]       s3_dat;
    logic             s3_enc;
    logic [TAG_W-1:0] s3_tag;

    // Ready ripples back from the output: a stage may load if it is empty
    // or its current contents move on in the same cycle.
    assign ld3      = !s3_vld || out_ready;
    assign ld2      = !s2_vld || ld3;
    assign ld1      = !s1_vld || ld2;
    assign in_ready = ld1;

    assign in_ah   = in_data[7:4];
    assign in_al   = in_data[3:0];
    assign d_c     = gf4_mul(LAMBDA, gf4_sq(in_ah)) ^ gf4_mul(in_ah, in_al) ^ gf4_sq(in_al);
    assign out_h_c = gf4_mul(s2_ah, s2_dinv);
    assign out_l_c = gf4_mul(s2_ah ^ s2_al, s2_dinv);

    gf4_inv u_gf4_inv (
        .a (s1_d),
        .y (dinv_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
            s3_vld <= 1'b0;
        end else begin
            if (ld1) s1_vld <= in_valid;
            if (ld2) s2_vld <= s1_vld;
            if (ld3) s3_vld <= s2_vld;
        end
    end

    // Payload registers carry no reset; they are only observed behind a valid bit.
    always_ff @(posedge clk) begin
        if (ld1 && in_valid) begin
            s1_d   <= d_c;
            s1_ah  <= in_ah;
            s1_al  <= in_al;
            s1_enc <= in_encrypt;
            s1_tag <= in_tag;
        end
        if (ld2 && s1_vld) begin
            s2_dinv <= dinv_c;
            s2_ah   <= s1_ah;
            s2_al   <= s1_al;
            s2_enc  <= s1_enc;
            s2_tag  <= s1_tag;
        end
        if (ld3 && s2_vld) begin
            s3_dat <= {out_h_c, out_l_c};
            s3_enc <= s2_enc;
            s3_tag <= s2_tag;
        end
    end

    assign out_valid   = s3_vld;
    assign out_data    = s3_dat;
    assign out_encrypt = s3_enc;
    assign out_tag     = s3_tag;
    assign occupancy   = {1'b0, s1_vld} + {1'b0, s2_vld} + {1'b0, s3_vld};

endmodule

// File: tb/tb_gf8_inv_pipe.sv
// Directed and scoreboarded bench for gf8_inv_pipe.
module tb_gf8_inv_pipe;

    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             in_encrypt;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             out_encrypt;
    logic [TAG_W-1:0] out_tag;
    logic [1:0]       occupancy;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0]       dat;
        logic             enc;
        logic [TAG_W-1:0] tag;
    } item_t;

    logic [7:0] inv_tab [256];
    item_t      exp_q [$];

    always #5 clk = ~clk;

    gf8_inv_pipe #(.TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_encrypt  (in_encrypt),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_encrypt (out_encrypt),
        .out_tag     (out_tag),
        .occupancy   (occupancy)
    );

    // Reference GF(2^4) multiply: full carry-less product, then long-division reduction.
    function automatic logic [3:0] m_mul4(input logic [3:0] a, input logic [3:0] b);
        logic [6:0] p;
        p = '0;
        for (int i = 0; i < 4; i++)
            if (b[i]) p = p ^ (7'(a) << i);
        for (int k = 6; k >= 4; k--)
            if (p[k]) p = p ^ (7'b001_0011 << (k - 4));
        return p[3:0];
    endfunction

    // (ah x + al)(bh x + bl) with x^2 = x + 0xC.
    function automatic logic [7:0] m_mul8(input logic [7:0] a, input logic [7:0] b);
        logic [3:0] hh;
        logic [3:0] hi;
        logic [3:0] lo;
        hh = m_mul4(a[7:4], b[7:4]);
        hi = hh ^ m_mul4(a[7:4], b[3:0]) ^ m_mul4(a[3:0], b[7:4]);
        lo = m_mul4(4'hC, hh) ^ m_mul4(a[3:0], b[3:0]);
        return {hi, lo};
    endfunction

    task automatic step(input logic iv, input logic [7:0] id, input logic ie,
                        input logic [TAG_W-1:0] it, input logic ordy);
        @(negedge clk);
        in_valid   = iv;
        in_data    = id;
        in_encrypt = ie;
        in_tag     = it;
        out_ready  = ordy;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        do_reset();
        step(1'b1, 8'h01, 1'b0, 4'h1, 1'b1);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_accept: in_ready got %b want 1", in_ready); end
        step(1'b1, 8'h00, 1'b0, 4'h2, 1'b1);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_lat1: out_valid got %b want 0", out_valid); end
        step(1'b0, 8'h00, 1'b0, 4'h0, 1'b1);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_lat2: out_valid got %b want 0", out_valid); end
        step(1'b0, 8'h00, 1'b0, 4'h0, 1'b1);
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'h01 || out_tag !== 4'h1) begin
            bad++; $display("FAIL basic_01: vld=%b data=%h tag=%h want vld=1 data=01 tag=1", out_valid, out_data, out_tag);
        end
        step(1'b0, 8'h00, 1'b0, 4'h0, 1'b1);
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'h00 || out_tag !== 4'h2) begin
            bad++; $display("FAIL basic_00: vld=%b data=%h tag=%h want vld=1 data=00 tag=2", out_valid, out_data, out_tag);
        end
        step(1'b0, 8'h00, 1'b0, 4'h0, 1'b1);
        total++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            bad++; $display("FAIL basic_drain: vld=%b occ=%0d want vld=0 occ=0", out_valid, occupancy);
        end
    endtask

    task automatic test_vectors();
        do_reset();
        step(1'b1, 8'h10, 1'b1, 4'h5, 1'b1);
        step(1'b1, 8'hC0, 1'b0, 4'h9, 1'b1);
        step(1'b0, 8'h00, 1'b0, 4'h0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 4'h0, 1'b1);
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'hAA || out_encrypt !== 1'b1 || out_tag !== 4'h5) begin
            bad++; $display("FAIL vec_10: vld=%b data=%h enc=%b tag=%h want 1/AA/1/5", out_valid, out_data, out_encrypt, out_tag);
        end
        step(1'b0, 8'h00, 1'b0, 4'h0, 1'b1);
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'h88 || out_encrypt !== 1'b0 || out_tag !== 4'h9) begin
            bad++; $display("FAIL vec_C0: vld=%b data=%h enc=%b tag=%h want 1/88/0/9", out_valid, out_data, out_encrypt, out_tag);
        end
    endtask

    task automatic test_sweep();
        int    sent = 0;
        int    got = 0;
        int    first = -1;
        int    last = -1;
        item_t e;
        do_reset();
        for (int cyc = 0; cyc < 300 && got < 256; cyc++) begin
            step(sent < 256, 8'(sent), sent[0], TAG_W'(sent), 1'b1);
            if (in_valid) begin
                total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL sweep_ready: cycle %0d got %b want 1", cyc, in_ready); end
            end
            if (out_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL sweep_spurious: data=%h with nothing expected", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.dat || out_tag !== e.tag || out_encrypt !== e.enc ||
                        (got != 0 && m_mul8(8'(got), out_data) !== 8'h01)) begin
                        bad++; $display("FAIL sweep_data: in=%h got %h/%h want %h/%h", 8'(got), out_data, out_tag, e.dat, e.tag);
                    end
                end
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back('{dat: inv_tab[in_data], enc: in_encrypt, tag: in_tag});
                sent++;
            end
        end
        total++; if (got !== 256) begin bad++; $display("FAIL sweep_count: got %0d want 256", got); end
        total++; if (first !== 3) begin bad++; $display("FAIL sweep_latency: first output cycle %0d want 3", first); end
        total++; if (last - first !== 255) begin bad++; $display("FAIL sweep_rate: span %0d want 255", last - first); end
    endtask

    task automatic test_stall();
        logic [7:0]       sb [5];
        logic [7:0]       hold_dat;
        logic [TAG_W-1:0] hold_tag;
        int               acc = 0;
        int               got = 0;
        item_t            e;
        sb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            step(acc < 5, (acc < 5) ? sb[acc] : 8'h00, 1'b1, TAG_W'(acc), 1'b0);
            if (in_valid && in_ready) begin
                exp_q.push_back('{dat: inv_tab[in_data], enc: in_encrypt, tag: in_tag});
                acc++;
            end
        end
        total++; if (acc !== 3) begin bad++; $display("FAIL stall_accepted: got %0d want 3", acc); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
        total++; if (occupancy !== 2'd3) begin bad++; $display("FAIL stall_occupancy: got %0d want 3", occupancy); end
        hold_dat = out_data;
        hold_tag = out_tag;
        for (int c = 0; c < 2; c++) begin
            step(1'b1, sb[3], 1'b1, TAG_W'(3), 1'b0);
            total++;
            if (out_valid !== 1'b1 || out_data !== hold_dat || out_tag !== hold_tag || in_ready !== 1'b0) begin
                bad++; $display("FAIL stall_hold: vld=%b data=%h tag=%h rdy=%b want 1/%h/%h/0", out_valid, out_data, out_tag, in_ready, hold_dat, hold_tag);
            end
        end
        for (int c = 0; c < 40 && got < 5; c++) begin
            step(acc < 5, (acc < 5) ? sb[acc] : 8'h00, 1'b1, TAG_W'(acc), 1'b1);
            if (out_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL stall_spurious: data=%h with nothing expected", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.dat || out_tag !== e.tag || out_encrypt !== e.enc) begin
                        bad++; $display("FAIL stall_order: got %h/%h want %h/%h", out_data, out_tag, e.dat, e.tag);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back('{dat: inv_tab[in_data], enc: in_encrypt, tag: in_tag});
                acc++;
            end
        end
        total++; if (got !== 5) begin bad++; $display("FAIL stall_release: got %0d outputs want 5", got); end
    endtask

    task automatic test_random();
        int    sent = 0;
        int    got = 0;
        int    cyc = 0;
        logic  iv;
        logic  ordy;
        item_t e;
        do_reset();
        while (got < 10000 && cyc < 60000) begin
            iv   = (sent < 10000) && ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            step(iv, 8'($urandom), 1'($urandom), TAG_W'(sent), ordy);
            total++;
            if (occupancy !== 2'(exp_q.size())) begin
                bad++; $display("FAIL rand_occupancy: cycle %0d got %0d want %0d", cyc, occupancy, exp_q.size());
            end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL rand_spurious: data=%h with nothing expected", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.dat || out_tag !== e.tag || out_encrypt !== e.enc) begin
                        bad++; $display("FAIL rand_data: got %h/%b/%h want %h/%b/%h", out_data, out_encrypt, out_tag, e.dat, e.enc, e.tag);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back('{dat: inv_tab[in_data], enc: in_encrypt, tag: in_tag});
                sent++;
            end
            cyc++;
        end
        total++; if (got !== 10000) begin bad++; $display("FAIL rand_count: got %0d want 10000", got); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rand_leftover: %0d bytes never emitted", exp_q.size()); end
    endtask

    task automatic test_reset_inflight();
        int seen = 0;
        do_reset();
        step(1'b1, 8'h22, 1'b0, 4'h3, 1'b0);
        step(1'b1, 8'h33, 1'b0, 4'h4, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL rif_inflight: occupancy got %0d want 2", occupancy); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL rif_cleared: vld=%b occ=%0d rdy=%b want 0/0/1", out_valid, occupancy, in_ready);
        end
        for (int c = 0; c < 6; c++) begin
            step(1'b0, 8'h00, 1'b0, 4'h0, 1'b1);
            if (out_valid) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL rif_discard: %0d stale outputs want 0", seen); end
        step(1'b1, 8'h10, 1'b1, 4'h7, 1'b1);
        step(1'b0, 8'h00, 1'b0, 4'h0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 4'h0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 4'h0, 1'b1);
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'hAA || out_encrypt !== 1'b1 || out_tag !== 4'h7) begin
            bad++; $display("FAIL rif_next: vld=%b data=%h enc=%b tag=%h want 1/AA/1/7", out_valid, out_data, out_encrypt, out_tag);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        in_encrypt = 1'b0;
        in_tag     = '0;
        out_ready  = 1'b0;
        // Inverse table by exhaustive search over the reference multiply.
        for (int a = 0; a < 256; a++) begin
            inv_tab[a] = 8'h00;
            for (int b = 1; b < 256; b++)
                if (m_mul8(8'(a), 8'(b)) == 8'h01) inv_tab[a] = 8'(b);
        end
        test_reset();
        test_basic();
        test_vectors();
        test_sweep();
        test_stall();
        test_random();
        test_reset_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gf8_inv_pipe.md
GF8_INV_PIPE -- requirements
Module: gf8_inv_pipe

Interface
REQ-001 SHALL have parameter TAG_W, default 4, width of the sideband tag (byte index within the state).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  upstream byte present.
REQ-005 SHALL have port in_ready  output  1  block accepts byte this cycle.
REQ-006 SHALL have port in_data  input  8  composite-field byte from preprocess; [7:4]=a_h, [3:0]=a_l.
REQ-007 SHALL have port in_encrypt  input  1  mode bit; travels with data to postprocess.
REQ-008 SHALL have port in_tag  input  TAG_W  opaque tag; travels with data.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  downstream (postprocess/collector) accepts.
REQ-011 SHALL have port out_data  output  8  composite-field inverse, same bit layout as in_data.
REQ-012 SHALL have ports out_encrypt (1) and out_tag (TAG_W), outputs, aligned with out_data.
REQ-013 SHALL have port occupancy  output  2  bytes in flight, 0..3.

Function
REQ-014 SHALL use GF(2^4) polynomial basis modulo y^4+y+1 and GF(2^8) = GF(2^4)[x]/(x^2+x+lambda), lambda=4'hC.
REQ-015 SHALL compute d = lambda*a_h^2 ^ a_h*a_l ^ a_l^2, d_inv = d^-1 (0 maps to 0), out_h = a_h*d_inv, out_l = (a_h^a_l)*d_inv.
REQ-016 SHALL map input 8'h00 to 8'h00.
REQ-017 SHALL be a 3-stage register pipeline: S1 registers d, a_h, a_l; S2 registers d_inv, a_h, a_l; S3 registers out_data.
REQ-018 SHALL carry encrypt and tag through every stage unchanged, beside the data.
REQ-019 SHALL have latency exactly 3 cycles from accepted input to out_valid when out_ready is held high.
REQ-020 SHALL sustain one byte per cycle throughput when out_ready is high.
REQ-021 Transfer SHALL occur on a cycle where valid and ready are both high, on either port.
REQ-022 Each stage SHALL load when it is empty or its contents advance in the same cycle; otherwise it SHALL hold data, sideband and valid.
REQ-023 in_ready SHALL be high iff S1 is empty or S1 advances this cycle; in_ready SHALL NOT depend combinationally on in_valid.
REQ-024 out_valid, out_data, out_encrypt and out_tag SHALL be driven directly from S3 registers.
REQ-025 While out_valid is high and out_ready low, out_data, out_encrypt and out_tag SHALL be stable.
REQ-026 With all three stages full and out_ready low, in_ready SHALL be low; no byte SHALL be dropped or duplicated.
REQ-027 Simultaneous input accept and output release SHALL leave occupancy unchanged.
REQ-028 occupancy SHALL equal the count of valid stage bits, registered-consistent with the same cycle's stage state.

Reset
REQ-029 rst high at a rising edge SHALL clear all stage valid bits; out_valid=0, occupancy=0 the following cycle.
REQ-030 Data, encrypt and tag registers SHALL NOT require reset; out_data/out_encrypt/out_tag are don't-care while out_valid=0.
REQ-031 in_ready SHALL be 1 in the first cycle after reset deasserts; in-flight bytes at reset SHALL be discarded, never emitted.

Structure
REQ-032 Package sbox_pkg SHALL hold gf4_t (4-bit) typedef, GF4 polynomial, LAMBDA=4'hC, and functions gf4_mul and gf4_sq.
REQ-033 GF(2^4) inversion SHALL be a separate sub-module gf4_inv (purely combinational, 4-in/4-out), instantiated once in S2.
REQ-034 All field arithmetic SHALL be XOR/AND logic; no lookup tables of 256 entries.

Verification
REQ-035 Reset then in 8'h01 -> out_data 8'h01 exactly 3 cycles after acceptance; 8'h00 -> 8'h00.
REQ-036 Input 8'h10, encrypt=1, tag=4'h5 -> out_data 8'hAA, out_encrypt=1, out_tag=4'h5.
REQ-037 Sweep all 256 inputs back-to-back, out_ready=1 -> one output per cycle, tags in order, model check in*out=1 for nonzero inputs.
REQ-038 Stream 5 bytes with out_ready=0 -> exactly 3 accepted, in_ready=0, occupancy=3; release -> all 5 emerge in order, out_data stable while stalled.
REQ-039 Random in_valid/out_ready toggling over 10k bytes -> scoreboard shows no loss, duplication or reordering; occupancy matches scoreboard depth.
REQ-040 Assert rst with 2 bytes in flight -> out_valid=0 next cycle, neither byte ever emitted, next byte after reset returns correct result.
